// File: rtl/lcd8080_pkg.sv
// Shared constants for the i8080-to-pixel-stream bridge: register map, reset values,
// CTRL bit positions and the RGB565 bar colour table.
package lcd8080_pkg;

  localparam logic [2:0] A_CTRL = 3'b001;
  localparam logic [2:0] A_PIX  = 3'b010;
  localparam logic [2:0] A_BL   = 3'b011;
  localparam logic [2:0] A_TEST = 3'b100;

  localparam logic [4:0] CTRL_RST = 5'b01000;
  localparam logic [4:0] PIX_RST  = 5'b00000;
  localparam logic [4:0] BL_RST   = 5'b00001;
  localparam logic [4:0] TEST_RST = 5'b00000;

  localparam int unsigned CTRL_BUS_MODE = 4;
  localparam int unsigned CTRL_AUTO     = 3;
  localparam int unsigned CTRL_PAT_INV  = 2;

  localparam int unsigned N_COLORS = 5;

  // Black, blue, green, red, white.
  function automatic logic [15:0] pat_color(input logic [2:0] idx);
    logic [15:0] c;
    c = 16'h0000;
    case (idx)
      3'd1:    c = 16'h001F;
      3'd2:    c = 16'h07E0;
      3'd3:    c = 16'hF800;
      3'd4:    c = 16'hFFFF;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd8080_sync.sv
// Synchroniser for the asynchronous i8080 write bus; emits a one-cycle write event
// with the RS/DATA values that were stable when the synchronised WR rose under CS.
module lcd8080_sync
  import lcd8080_pkg::*;
#(
  parameter int unsigned BUS_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cs_n,
  input  logic             i_rs,
  input  logic             i_wr,
  input  logic [BUS_W-1:0] i_data,
  output logic             o_evt,
  output logic             o_rs,
  output logic [BUS_W-1:0] o_data
);

  localparam int unsigned SW = BUS_W + 3;
  // Idle bus: CS and WR high, so leaving reset never fakes a WR edge.
  localparam logic [SW-1:0] SYNC_RST = {1'b1, 1'b0, 1'b1, {BUS_W{1'b0}}};

  logic [SW-1:0]    r_sync [SYNC_STAGES];
  logic             r_wr_d;
  logic             r_evt;
  logic             r_rs;
  logic [BUS_W-1:0] r_data;

  logic [SW-1:0]    w_in;
  logic [SW-1:0]    w_last;
  logic             w_cs_s;
  logic             w_rs_s;
  logic             w_wr_s;
  logic [BUS_W-1:0] w_data_s;

  assign w_in     = {i_cs_n, i_rs, i_wr, i_data};
  assign w_last   = r_sync[SYNC_STAGES-1];
  assign w_cs_s   = w_last[BUS_W+2];
  assign w_rs_s   = w_last[BUS_W+1];
  assign w_wr_s   = w_last[BUS_W];
  assign w_data_s = w_last[BUS_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= SYNC_RST;
      r_wr_d <= 1'b1;
      r_evt  <= 1'b0;
      r_rs   <= 1'b0;
      r_data <= '0;
    end else begin
      r_sync[0] <= w_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
      r_wr_d <= w_wr_s;
      r_evt  <= w_wr_s & ~r_wr_d & ~w_cs_s;
      r_rs   <= w_rs_s;
      r_data <= w_data_s;
    end
  end

  assign o_evt  = r_evt;
  assign o_rs   = r_rs;
  assign o_data = r_data;

endmodule

// File: rtl/lcd8080_bridge.sv
// i8080 write bus to valid/ready pixel stream, with bar test-pattern generator.
// Optional LCD8080_PIXCNT_EN adds PIX_CNT, the accepted-pixel count per frame.
module lcd8080_bridge
  import lcd8080_pkg::*;
#(
  parameter int unsigned BUS_W       = 8,
  parameter int unsigned PIX_W       = 16,
  parameter int unsigned H_ACT       = 800,
  parameter int unsigned N_BARS      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             HSYNC,
  input  logic             VSYNC,
  input  logic             J80_CS,
  input  logic             J80_RS,
  input  logic             J80_WR,
  input  logic [BUS_W-1:0] J80_DATA,
  output logic [PIX_W-1:0] PIX_DATA,
  output logic             PIX_VALID,
  input  logic             PIX_READY,
  output logic             TE,
  output logic             FRAME_EN,
  output logic             LCD_BL,
  output logic             OVF
`ifdef LCD8080_PIXCNT_EN
  ,
  output logic [23:0]      PIX_CNT
`endif
);

  localparam int unsigned BEATS  = PIX_W / BUS_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = $clog2(H_ACT + 1);
  localparam int unsigned BAR_W  = H_ACT / N_BARS;

  logic [4:0]       r_ctrl, r_pix, r_bl, r_test;
  logic [PIX_W-1:0] r_pack;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [PIX_W-1:0] r_pdata;
  logic             r_ovf;
  logic             r_te, r_frame_en, r_lcd_bl;

  logic             w_evt, w_rs;
  logic [BUS_W-1:0] w_data;
  logic             w_reg_wr, w_pix_evt, w_last_beat, w_mode_sw, w_sync;
  logic [2:0]       w_addr;
  logic [4:0]       w_val;
  logic [PIX_W-1:0] w_pack_nxt;
  logic             w_bus_new, w_pat_new, w_new;
  logic [PIX_W-1:0] w_pat_color, w_new_data;
  logic             w_unused;

  lcd8080_sync #(
    .BUS_W      (BUS_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_cs_n(J80_CS),
    .i_rs  (J80_RS),
    .i_wr  (J80_WR),
    .i_data(J80_DATA),
    .o_evt (w_evt),
    .o_rs  (w_rs),
    .o_data(w_data)
  );

  assign w_reg_wr    = w_evt & w_rs;
  assign w_addr      = w_data[BUS_W-1 -: 3];
  assign w_val       = w_data[4:0];
  assign w_pix_evt   = w_evt & ~w_rs & r_ctrl[CTRL_BUS_MODE];
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_mode_sw   = w_reg_wr && (w_addr == A_CTRL) &&
                       (w_val[CTRL_BUS_MODE] != r_ctrl[CTRL_BUS_MODE]);
  assign w_sync      = HSYNC | VSYNC;

  if (BEATS == 1) begin : g_single
    assign w_pack_nxt = PIX_W'(w_data);
  end else begin : g_multi
    assign w_pack_nxt = {r_pack[PIX_W-BUS_W-1:0], w_data};
  end

  assign w_bus_new = w_pix_evt & w_last_beat;
  assign w_pat_new = ~r_ctrl[CTRL_BUS_MODE] & ~w_sync & ~w_mode_sw &
                     (r_cnt < CNT_W'(H_ACT)) & (~r_valid | PIX_READY);
  assign w_new      = w_bus_new | w_pat_new;
  assign w_new_data = w_bus_new ? w_pack_nxt : w_pat_color;

  // Bar colour for the current line position, or the solid TEST colour.
  always_comb begin
    int unsigned bar;
    w_pat_color = '0;
    bar = 32'(r_cnt) / BAR_W;
    if (r_test[3:0] != 4'd0)
      w_pat_color = PIX_W'(pat_color(3'(32'(r_test[2:0]) % N_COLORS)));
    else
      w_pat_color = PIX_W'(pat_color(3'(bar % N_COLORS))) ^ {PIX_W{r_ctrl[CTRL_PAT_INV]}};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ctrl     <= CTRL_RST;
      r_pix      <= PIX_RST;
      r_bl       <= BL_RST;
      r_test     <= TEST_RST;
      r_pack     <= '0;
      r_beat     <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_pdata    <= '0;
      r_ovf      <= 1'b0;
      r_te       <= 1'b0;
      r_frame_en <= 1'b1;
      r_lcd_bl   <= 1'b1;
    end else begin
      if (w_reg_wr) begin
        case (w_addr)
          A_CTRL:  r_ctrl <= w_val;
          A_PIX:   r_pix  <= w_val;
          A_BL:    r_bl   <= w_val;
          A_TEST:  r_test <= w_val;
          default: ;
        endcase
      end

      if (w_reg_wr) begin
        r_beat <= '0;
      end else if (w_pix_evt) begin
        r_pack <= w_pack_nxt;
        r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
      end

      if (w_mode_sw || w_sync) r_cnt <= '0;
      else if (w_pat_new)      r_cnt <= r_cnt + CNT_W'(1);

      // A held, unaccepted pixel wins; a pixel completing behind it is lost.
      if (r_valid && !PIX_READY) begin
        if (w_new) r_ovf <= 1'b1;
      end else begin
        r_valid <= w_new;
        if (w_new) r_pdata <= w_new_data;
      end
      if (w_reg_wr && (w_addr == A_TEST) && w_val[4]) r_ovf <= 1'b0;

      r_lcd_bl   <= r_bl[0];
      r_frame_en <= r_ctrl[CTRL_AUTO] | r_pix[0];
      r_te       <= r_ctrl[CTRL_AUTO] ? (HSYNC | VSYNC) : (HSYNC & ~VSYNC);
    end
  end

  assign PIX_DATA  = r_pdata;
  assign PIX_VALID = r_valid;
  assign OVF       = r_ovf;
  assign TE        = r_te;
  assign FRAME_EN  = r_frame_en;
  assign LCD_BL    = r_lcd_bl;

`ifdef LCD8080_PIXCNT_EN
  logic        r_vs_d;
  logic [23:0] r_run, r_pix_cnt;
  logic        w_acc;

  assign w_acc = r_valid & PIX_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vs_d    <= 1'b0;
      r_run     <= '0;
      r_pix_cnt <= '0;
    end else begin
      r_vs_d <= VSYNC;
      if (VSYNC && !r_vs_d) begin
        r_pix_cnt <= r_run;
        r_run     <= 24'(w_acc);
      end else if (w_acc) begin
        r_run <= r_run + 24'd1;
      end
    end
  end

  assign PIX_CNT = r_pix_cnt;
`endif

  assign w_unused = ^{r_ctrl[1:0], r_pix[4:1], r_bl[4:1], r_test[4], w_data};

endmodule

// File: tb/tb_lcd8080_bridge.sv
// Randomised bench for lcd8080_bridge against a transaction-level model of the
// register map, byte packing and bar pattern.
module tb_lcd8080_bridge;

  localparam int unsigned BUS_W       = 8;
  localparam int unsigned PIX_W       = 16;
  localparam int unsigned H_ACT       = 800;
  localparam int unsigned N_BARS      = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned BAR_LEN     = H_ACT / N_BARS;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             HSYNC = 1'b1;
  logic             VSYNC = 1'b0;
  logic             J80_CS = 1'b1;
  logic             J80_RS = 1'b0;
  logic             J80_WR = 1'b1;
  logic [BUS_W-1:0] J80_DATA = '0;
  logic             PIX_READY = 1'b1;
  logic [PIX_W-1:0] PIX_DATA;
  logic             PIX_VALID;
  logic             TE, FRAME_EN, LCD_BL, OVF;
`ifdef LCD8080_PIXCNT_EN
  logic [23:0]      PIX_CNT;
`endif

  lcd8080_bridge #(
    .BUS_W(BUS_W), .PIX_W(PIX_W), .H_ACT(H_ACT), .N_BARS(N_BARS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK(CLK), .RST(RST), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .J80_CS(J80_CS), .J80_RS(J80_RS), .J80_WR(J80_WR), .J80_DATA(J80_DATA),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .TE(TE), .FRAME_EN(FRAME_EN), .LCD_BL(LCD_BL), .OVF(OVF)
`ifdef LCD8080_PIXCNT_EN
    , .PIX_CNT(PIX_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  logic [4:0]  m_ctrl = 5'b01000;
  logic [4:0]  m_pix  = 5'b00000;
  logic [4:0]  m_bl   = 5'b00001;
  logic [4:0]  m_test = 5'b00000;
  logic [7:0]  m_bytes[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_tbl[5] = '{16'h0000, 16'h001F, 16'h07E0, 16'hF800, 16'hFFFF};

  // Observed stream
  logic [15:0] got_q[$];
  int          n_valid = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (PIX_VALID) n_valid++;
      if (PIX_VALID && PIX_READY) got_q.push_back(PIX_DATA);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic host_write(input logic rs, input logic [7:0] d);
    J80_CS = 1'b0; J80_RS = rs; J80_DATA = d; J80_WR = 1'b0;
    tick(SYNC_STAGES + 2);
    J80_WR = 1'b1;
    tick(SYNC_STAGES + 4);
    J80_CS = 1'b1;
  endtask

  task automatic reg_write(input logic [7:0] d);
    host_write(1'b1, d);
    case (d[7:5])
      3'd1: m_ctrl = d[4:0];
      3'd2: m_pix  = d[4:0];
      3'd3: m_bl   = d[4:0];
      3'd4: m_test = d[4:0];
      default: ;
    endcase
    m_bytes.delete();
  endtask

  task automatic pix_write(input logic [7:0] d);
    host_write(1'b0, d);
    if (m_ctrl[4]) begin
      m_bytes.push_back(d);
      if (m_bytes.size() == PIX_W / BUS_W) begin
        exp_q.push_back({m_bytes[0], m_bytes[1]});
        m_bytes.delete();
      end
    end
  endtask

  task automatic check_ctrl(input string tag);
    logic te;
    te = m_ctrl[3] ? (HSYNC | VSYNC) : (HSYNC & ~VSYNC);
    check({tag, " lcd_bl"}, LCD_BL, m_bl[0]);
    check({tag, " frame_en"}, FRAME_EN, m_ctrl[3] | m_pix[0]);
    check({tag, " te"}, TE, te);
  endtask

  function automatic logic [15:0] exp_pat(input int i);
    if (m_test[3:0] != 4'd0) return m_tbl[int'(m_test[2:0]) % 5];
    return m_tbl[(i / BAR_LEN) % 5] ^ {16{m_ctrl[2]}};
  endfunction

  // One line of pattern output; with_prefix allows a partial line before a restart.
  task automatic check_line(input string tag, input bit with_prefix);
    int k;
    k = with_prefix ? got_q.size() - int'(H_ACT) : 0;
    if (with_prefix) check({tag, " prefix>0"}, (k > 0), 1'b1);
    else             check({tag, " count"}, got_q.size(), H_ACT);
    if (k < 0) k = 0;
    if (with_prefix && got_q.size() > k)
      check({tag, " restart px"}, got_q[k], exp_pat(0));
    for (int i = 0; i < got_q.size(); i++)
      check($sformatf("%s px%0d", tag, i), got_q[i], (i < k) ? exp_pat(i) : exp_pat(i - k));
  endtask

  task automatic run_line(input int cycles, input bit rnd_ready);
    got_q.delete();
    HSYNC = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      PIX_READY = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick(1);
    end
    HSYNC = 1'b1; PIX_READY = 1'b1;
    tick(4);
  endtask

  task automatic run_pulse();
    got_q.delete();
    HSYNC = 1'b0; tick(300);
    HSYNC = 1'b1; tick(2);
    HSYNC = 1'b0; tick(900);
    HSYNC = 1'b1; tick(4);
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] a;

    // Reset
    tick(2);
    check("rst lcd_bl", LCD_BL, 1'b1);
    check("rst frame_en", FRAME_EN, 1'b1);
    check("rst valid", PIX_VALID, 1'b0);
    check("rst data", PIX_DATA, 16'h0000);
    check("rst ovf", OVF, 1'b0);
    check("rst te", TE, 1'b0);
    RST = 1'b0;
    tick(2);
    check_ctrl("post-rst");

    // Random register writes (HSYNC held high so the pattern stays idle)
    for (int n = 0; n < 12; n++) begin
      VSYNC = $urandom_range(0, 1);
      do a = 3'($urandom_range(0, 7)); while (a == 3'd4);
      d = {a, 5'($urandom_range(0, 31))};
      reg_write(d);
      check_ctrl($sformatf("rnd reg %0h", d));
    end
    VSYNC = 1'b0;
    check("rnd reg no px", got_q.size(), 0);

    reg_write(8'h60); check_ctrl("bl off");
    check("bl off lcd_bl", LCD_BL, 1'b0);
    reg_write(8'h28); check_ctrl("auto");
    check("auto frame_en", FRAME_EN, 1'b1);
    reg_write(8'h30); check_ctrl("bus mode");

    // Bus mode: one pixel, exactly one valid cycle
    HSYNC = 1'b0; PIX_READY = 1'b1;
    got_q.delete(); exp_q.delete(); n_valid = 0;
    pix_write(8'hF8); pix_write(8'h00);
    tick(3);
    check("bus1 count", got_q.size(), 1);
    if (got_q.size() > 0) check("bus1 px", got_q[0], 16'hF800);
    check("bus1 valid cycles", n_valid, 1);

    // Bus mode: random pixels
    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 12; n++) pix_write(8'($urandom_range(0, 255)));
    tick(3);
    check("bus rnd count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("bus rnd px%0d", i), got_q[i], exp_q[i]);

    // Overflow: held pixel survives, OVF sticky until TEST[4] write
    PIX_READY = 1'b0; got_q.delete();
    pix_write(8'hA1); pix_write(8'hB2);
    check("ovf held valid", PIX_VALID, 1'b1);
    check("ovf held data", PIX_DATA, 16'hA1B2);
    check("ovf pre", OVF, 1'b0);
    pix_write(8'hC3); pix_write(8'hD4);
    check("ovf set", OVF, 1'b1);
    check("ovf data kept", PIX_DATA, 16'hA1B2);
    reg_write(8'h90);
    check("ovf cleared", OVF, 1'b0);
    check("ovf still valid", PIX_VALID, 1'b1);
    PIX_READY = 1'b1; tick(2);
    check("ovf drain count", got_q.size(), 1);
    if (got_q.size() > 0) check("ovf drain px", got_q[0], 16'hA1B2);
    check("ovf drain valid", PIX_VALID, 1'b0);

    // Pattern mode; host pixel bytes are discarded
    HSYNC = 1'b1;
    reg_write(8'h28);
    got_q.delete();
    pix_write(8'h55);
    tick(2);
    check("pat host discard", got_q.size(), 0);
    check("pat host no ovf", OVF, 1'b0);
    check_ctrl("pat");

    run_line(900, 1'b0);
    check_line("line plain", 1'b0);

    reg_write(8'h2C);
    run_line(2500, 1'b1);
    check_line("line inv rnd", 1'b0);

    reg_write(8'h28);
    reg_write(8'h80 | 8'($urandom_range(1, 15)));
    run_line(2500, 1'b1);
    check_line("line solid", 1'b0);
    reg_write(8'h80);

    run_pulse();
    check_line("pulse plain", 1'b1);
    reg_write(8'h2C);
    run_pulse();
    check_line("pulse inv", 1'b1);
    check_ctrl("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
